// File: rtl/mips_pkg.sv
// Shared MIPS memory-interface definitions: load/store opcodes, size codes,
// responder FSM encoding and the request legality check.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  // Size codes are op[2:0] of the load/store opcode.
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b011;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  // High when the latched request must be rejected without touching memory.
  function automatic logic access_err(input logic [2:0] size,
                                      input logic [1:0] lane,
                                      input logic       is_store,
                                      input logic       both_req);
    logic e;
    e = both_req;
    case (size)
      SZ_B:    e = e;
      SZ_H:    if (lane[0]) e = 1'b1;
      SZ_W:    if (lane != 2'b00) e = 1'b1;
      SZ_BU:   if (is_store) e = 1'b1;
      SZ_HU:   if (is_store || lane[0]) e = 1'b1;
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: merges a store byte/half into the old word and
// extracts plus sign/zero-extends a load byte/half from the stored word.
module mem_lane_align
  import mips_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] store_word_o,
  output logic [31:0] load_data_o
);

  logic [4:0]  bit_off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_ok;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    bit_off      = {lane_i, 3'b000};
    byte_sel     = old_word_i[bit_off +: 8];
    half_sel     = lane_i[1] ? old_word_i[31:16] : old_word_i[15:0];
    sign_ok      = ~size_i[2];
    store_word_o = old_word_i;
    load_data_o  = old_word_i;
    case (size_i)
      SZ_B, SZ_BU: begin
        store_word_o[bit_off +: 8] = wdata_i[7:0];
        load_data_o                = {{24{byte_sel[7] & sign_ok}}, byte_sel};
      end
      SZ_H, SZ_HU: begin
        if (lane_i[1]) store_word_o[31:16] = wdata_i[15:0];
        else           store_word_o[15:0]  = wdata_i[15:0];
        load_data_o = {{16{half_sel[15] & sign_ok}}, half_sel};
      end
      default: store_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the multicycle MIPS controller: one load/store at a
// time, fixed LATENCY from acceptance to a one-cycle ready pulse.
module data_mem_responder
  import mips_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ready,
  output logic        err,
  output logic [31:0] rdata
);

  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [2:0]          size_q;
  logic [1:0]          lane_q;
  logic [ADDR_W-1:0]   word_q;
  logic [31:0]         wdata_q;
  logic                store_q, both_q;
  logic [31:0]         rdata_q;
  logic [31:0]         mem [DEPTH];

  logic [31:0]         old_word, store_word, load_data;
  logic                req, accept, access, req_err;
  logic                unused_bits;

  assign unused_bits = ^{op[5:3], addr[31:ADDR_W+2]};

  assign req      = MemRead || MemWrite;
  assign accept   = (state_q == ST_IDLE) && req;
  assign access   = (state_q == ST_BUSY) && (cnt_q == 4'd0);
  assign old_word = mem[word_q];
  assign req_err  = access_err(size_q, lane_q, store_q, both_q);

  mem_lane_align u_align (
    .size_i       (size_q),
    .lane_i       (lane_q),
    .old_word_i   (old_word),
    .wdata_i      (wdata_q),
    .store_word_o (store_word),
    .load_data_o  (load_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (req) begin
        state_d = ST_BUSY;
        cnt_d   = CNT_INIT;
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (access && !req_err && !store_q) rdata_q <= load_data;
      else if (state_q == ST_DONE)        rdata_q <= '0;
    end
  end

  // Request fields are only consumed after acceptance, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      size_q  <= op[2:0];
      lane_q  <= addr[1:0];
      word_q  <= addr[ADDR_W+1:2];
      wdata_q <= wdata;
      store_q <= MemWrite;
      both_q  <= MemRead && MemWrite;
    end
  end

  // NOTE: the array is never reset; reset only gates the write so an aborted store has no effect.
  always_ff @(posedge clk) begin
    if (access && store_q && !req_err && !reset) mem[word_q] <= store_word;
  end

  assign busy  = (state_q != ST_IDLE);
  assign ready = (state_q == ST_DONE);
  assign err   = ready && req_err;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench for data_mem_responder at LATENCY 2, 3 and 1.
module tb_data_mem_responder;
  import mips_pkg::*;

  typedef struct {
    string       tag;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk, reset;
  logic        mr [3];
  logic        mw [3];
  logic [5:0]  op;
  logic [31:0] addr, wdata;
  logic        busy_w  [3];
  logic        ready_w [3];
  logic        err_w   [3];
  logic [31:0] rdata_w [3];

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   extra_cnt;

  data_mem_responder #(.ADDR_W(10), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(reset), .MemRead(mr[0]), .MemWrite(mw[0]), .op(op), .addr(addr),
    .wdata(wdata), .busy(busy_w[0]), .ready(ready_w[0]), .err(err_w[0]), .rdata(rdata_w[0]));

  data_mem_responder #(.ADDR_W(10), .LATENCY(3)) u_dut_l3 (
    .clk(clk), .reset(reset), .MemRead(mr[1]), .MemWrite(mw[1]), .op(op), .addr(addr),
    .wdata(wdata), .busy(busy_w[1]), .ready(ready_w[1]), .err(err_w[1]), .rdata(rdata_w[1]));

  data_mem_responder #(.ADDR_W(10), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset), .MemRead(mr[2]), .MemWrite(mw[2]), .op(op), .addr(addr),
    .wdata(wdata), .busy(busy_w[2]), .ready(ready_w[2]), .err(err_w[2]), .rdata(rdata_w[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Drives one request on DUT d (starting at a negedge), waits for its ready pulse
  // and compares against the scoreboard entry pushed here.
  task automatic run_req(input int d, input logic rd, input logic wr, input logic [5:0] o,
                         input logic [31:0] a, input logic [31:0] wd, input logic e_err,
                         input logic [31:0] e_rd, input bit hold, input string tag);
    exp_t e;
    bit   seen;
    int   extra;
    sb.push_back('{tag, e_err, e_rd});
    mr[d] = rd; mw[d] = wr; op = o; addr = a; wdata = wd;
    @(posedge clk); #1;
    check({tag, " busy@accept"}, 32'(busy_w[d]), 32'd1);
    @(negedge clk);
    if (hold) begin
      addr = a + 32'd4;
    end else begin
      mr[d] = 1'b0; mw[d] = 1'b0;
      addr = $urandom; wdata = $urandom;
    end
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk); @(negedge clk);
      if (ready_w[d]) begin
        seen = 1'b1;
        mr[d] = 1'b0; mw[d] = 1'b0;
        check({tag, " latency"}, k, lat_of(d));
        if (sb.size() == 0) begin
          check({tag, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          check({e.tag, " err"}, 32'(err_w[d]), 32'(e.err));
          check({e.tag, " rdata"}, rdata_w[d], e.rdata);
        end
      end else if (hold) begin
        addr = addr + 32'd4;
      end
    end
    check({tag, " ready seen"}, 32'(seen), 32'd1);
    if (!seen) sb.delete();
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 0) check({tag, " busy after done"}, 32'(busy_w[d]), 32'd0);
      if (ready_w[d]) extra++;
    end
    check({tag, " extra ready"}, extra, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin mr[i] = 1'b0; mw[i] = 1'b0; end
    op = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy",  32'(busy_w[0]),  32'd0);
    check("reset ready", 32'(ready_w[0]), 32'd0);
    check("reset err",   32'(err_w[0]),   32'd0);
    check("reset rdata", rdata_w[0],      32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Size/sign rules and lane merging, LATENCY=2.
    run_req(0, 0, 1, OP_SW,  32'h10, 32'hDEADBEEF, 0, 32'h0,        0, "sw 10");
    run_req(0, 1, 0, OP_LW,  32'h10, 32'h0,        0, 32'hDEADBEEF, 0, "lw 10 a");
    run_req(0, 0, 1, OP_SB,  32'h11, 32'h000000A5, 0, 32'h0,        0, "sb 11");
    run_req(0, 1, 0, OP_LW,  32'h10, 32'h0,        0, 32'hDEADA5EF, 0, "lw 10 b");
    run_req(0, 1, 0, OP_LB,  32'h11, 32'h0,        0, 32'hFFFFFFA5, 0, "lb 11");
    run_req(0, 1, 0, OP_LBU, 32'h11, 32'h0,        0, 32'h000000A5, 0, "lbu 11");
    run_req(0, 0, 1, OP_SH,  32'h12, 32'h00008001, 0, 32'h0,        0, "sh 12");
    run_req(0, 1, 0, OP_LH,  32'h12, 32'h0,        0, 32'hFFFF8001, 0, "lh 12");
    run_req(0, 1, 0, OP_LHU, 32'h12, 32'h0,        0, 32'h00008001, 0, "lhu 12");
    run_req(0, 1, 0, OP_LH,  32'h10, 32'h0,        0, 32'hFFFFA5EF, 0, "lh 10");
    run_req(0, 1, 0, OP_LW,  32'h10, 32'h0,        0, 32'h8001A5EF, 0, "lw 10 c");

    // Error cases: misalignment, conflicting request, illegal size codes.
    run_req(0, 1, 0, OP_LW,  32'h13, 32'h0,        1, 32'h0,        0, "lw 13 misalign");
    run_req(0, 0, 1, OP_SW,  32'h14, 32'h0BADF00D, 0, 32'h0,        0, "sw 14");
    run_req(0, 0, 1, OP_SH,  32'h15, 32'h0000FFFF, 1, 32'h0,        0, "sh 15 misalign");
    run_req(0, 1, 0, OP_LW,  32'h14, 32'h0,        0, 32'h0BADF00D, 0, "lw 14 unchanged");
    run_req(0, 1, 1, OP_SW,  32'h10, 32'h0,        1, 32'h0,        0, "rd+wr both");
    run_req(0, 1, 0, 6'b100010, 32'h10, 32'h0,     1, 32'h0,        0, "illegal size");
    run_req(0, 0, 1, 6'b101100, 32'h10, 32'hFF,    1, 32'h0,        0, "store unsigned");
    run_req(0, 1, 0, OP_LW,  32'h10, 32'h0,        0, 32'h8001A5EF, 0, "lw 10 after errs");
    run_req(0, 1, 0, OP_LW,  32'h1010, 32'h0,      0, 32'h8001A5EF, 0, "lw alias");

    // Request held through BUSY/DONE with a moving address.
    run_req(0, 1, 0, OP_LW,  32'h10, 32'h0,        0, 32'h8001A5EF, 1, "lw 10 held");

    // Reset one cycle after acceptance aborts the store, LATENCY=3.
    run_req(1, 0, 1, OP_SW,  32'h20, 32'h11223344, 0, 32'h0,        0, "l3 sw 20");
    run_req(1, 1, 0, OP_LW,  32'h20, 32'h0,        0, 32'h11223344, 0, "l3 lw 20 a");
    mw[1] = 1'b1; op = OP_SW; addr = 32'h20; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    check("abort busy@accept", 32'(busy_w[1]), 32'd1);
    @(negedge clk);
    mw[1] = 1'b0; reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    check("abort busy after reset", 32'(busy_w[1]), 32'd0);
    extra_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); @(negedge clk);
      if (ready_w[1]) extra_cnt++;
    end
    check("abort no ready", extra_cnt, 32'd0);
    run_req(1, 1, 0, OP_LW,  32'h20, 32'h0,        0, 32'h11223344, 0, "l3 lw 20 kept");

    // LATENCY=1 build.
    run_req(2, 0, 1, OP_SW,  32'h40, 32'h12345678, 0, 32'h0,        0, "l1 sw 40");
    run_req(2, 1, 0, OP_LW,  32'h40, 32'h0,        0, 32'h12345678, 0, "l1 lw 40");
    run_req(2, 1, 0, OP_LBU, 32'h43, 32'h0,        0, 32'h00000012, 0, "l1 lbu 43");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
